// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED countdown/scan display.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   SEG_BLANK, SEG_0..SEG_9  active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   bcd_dec_borrow           one nibble of a ripple-borrow BCD decrement
package led_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decrement one BCD nibble when borrow_in is set.
  // Returns {borrow_out, nibble_out}; a nibble at 0 becomes 9 and borrows onward.
  function automatic logic [4:0] bcd_dec_borrow(input logic [3:0] nib,
                                                input logic       borrow_in);
    logic [4:0] r;
    if (!borrow_in) begin
      r = {1'b0, nib};
    end else if (nib == 4'd0) begin
      r = {1'b1, 4'd9};
    end else begin
      r = {1'b0, nib - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern; values above 9 show blank.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   bcd  in   4  BCD digit
//   seg  out  7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import led_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_countdown_scan.sv
// Multiplexed 7-segment scan controller with a built-in BCD countdown timer.
// Latency: led_en/led_seg follow the digit index by 1 clk; done is registered.
// Backpressure: none; start/pause are sampled every cycle.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start        1-cycle pulse: latch load_val and (re)start the countdown
//   pause        level: freeze the countdown, scanning continues
//   load_val     BCD start value, nibble 0 least significant
//   static_bcd   BCD for the lower digits, nibble i -> digit i
//   led_en       digit enables, active-low, one-hot-zero
//   led_seg      segments {g,f,e,d,c,b,a}, active-low
//   led_dp       decimal point, always off
//   running      countdown active
//   done         1-cycle pulse when the count reaches 0
module led_countdown_scan
  import led_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CNT_DIGITS  = 2,
  parameter int SCAN_DIV    = 200_000,
  parameter int TICK_DIV    = 100_000_000,
  parameter int AUTO_RELOAD = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pause,
  input  logic [4*CNT_DIGITS-1:0]            load_val,
  input  logic [4*(NUM_DIGITS-CNT_DIGITS)-1:0] static_bcd,
  output logic [NUM_DIGITS-1:0]              led_en,
  output logic [6:0]                         led_seg,
  output logic                               led_dp,
  output logic                               running,
  output logic                               done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = 4 * CNT_DIGITS;
  localparam int SD = NUM_DIGITS - CNT_DIGITS;  // number of static digits

  logic [SW-1:0] scan_div;
  logic [TW-1:0] tick_div;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic [CW-1:0] reload;
  logic [CW-1:0] cnt_dec;
  logic          armed;
  logic          tick;
  logic          count_zero;
  logic          dec_zero;
  logic [3:0]    dig_nib;
  logic [6:0]    dig_seg;

  assign led_dp = 1'b1;

  // Ripple-borrow BCD decrement of the whole count, LSD first.
  always_comb begin
    logic       borrow;
    logic [4:0] r;
    borrow  = 1'b1;
    r       = '0;
    cnt_dec = '0;
    for (int k = 0; k < CNT_DIGITS; k++) begin
      r                  = bcd_dec_borrow(count[4*k +: 4], borrow);
      cnt_dec[4*k +: 4]  = r[3:0];
      borrow             = r[4];
    end
  end

  assign count_zero = (count == '0);
  assign dec_zero   = (cnt_dec == '0);
  assign tick       = running && !pause && (tick_div == TW'(TICK_DIV - 1));

  // Countdown, reload and tick divider.
  // With auto-reload the terminal count is not reported: the timer simply
  // wraps back to the reload value one tick after showing zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      reload   <= '0;
      tick_div <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        count    <= load_val;
        reload   <= load_val;
        tick_div <= '0;
        armed    <= 1'b1;
        if (load_val == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          running <= 1'b1;
        end
      end else if (running && !pause) begin
        if (tick) begin
          tick_div <= '0;
          if (count_zero) begin
            if (AUTO_RELOAD != 0) count <= reload;
          end else begin
            count <= cnt_dec;
            if (dec_zero && (AUTO_RELOAD == 0)) begin
              done    <= 1'b1;
              running <= 1'b0;
            end
          end
        end else begin
          tick_div <= tick_div + TW'(1);
        end
      end
    end
  end

  // Scan divider and digit index; idle until the first start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_div <= '0;
      idx      <= '0;
    end else if (armed) begin
      if (scan_div == SW'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        if (idx == IW'(NUM_DIGITS - 1)) idx <= '0;
        else                            idx <= idx + IW'(1);
      end else begin
        scan_div <= scan_div + SW'(1);
      end
    end
  end

  // Digit mux: low digits from static_bcd, high digits from the count.
  always_comb begin
    dig_nib = 4'hF;
    for (int d = 0; d < SD; d++) begin
      if (idx == IW'(d)) dig_nib = static_bcd[4*d +: 4];
    end
    for (int k = 0; k < CNT_DIGITS; k++) begin
      if (idx == IW'(SD + k)) dig_nib = count[4*k +: 4];
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (dig_nib),
    .seg (dig_seg)
  );

  // Enable and segments are registered together from the same index so a
  // digit is never lit with its neighbour's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en  <= '1;
      led_seg <= SEG_BLANK;
    end else if (armed) begin
      led_en  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
      led_seg <= dig_seg;
    end else begin
      led_en  <= '1;
      led_seg <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_led_countdown_scan.sv
// Self-checking bench: two DUTs (no auto-reload / auto-reload) share stimulus
// and are compared every cycle against a decimal-arithmetic reference model.
module tb_led_countdown_scan;

  localparam int ND = 4;
  localparam int CD = 2;
  localparam int SD = 4;
  localparam int TD = 20;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [7:0] load_val, static_bcd;
  logic [3:0] en0, en1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, run0, run1, done0, done1;

  int errors = 0;
  int checks = 0;
  int dcount0 = 0;
  int dcount1 = 0;

  always #5 clk = ~clk;

  led_countdown_scan #(.NUM_DIGITS(ND), .CNT_DIGITS(CD), .SCAN_DIV(SD),
                       .TICK_DIV(TD), .AUTO_RELOAD(0)) u_ar0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load_val(load_val),
    .static_bcd(static_bcd), .led_en(en0), .led_seg(seg0), .led_dp(dp0),
    .running(run0), .done(done0));

  led_countdown_scan #(.NUM_DIGITS(ND), .CNT_DIGITS(CD), .SCAN_DIV(SD),
                       .TICK_DIV(TD), .AUTO_RELOAD(1)) u_ar1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load_val(load_val),
    .static_bcd(static_bcd), .led_en(en1), .led_seg(seg1), .led_dp(dp1),
    .running(run1), .done(done1));

  // Reference patterns for digits 0..9, {g,f,e,d,c,b,a} active-low.
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state per instance (index = AUTO_RELOAD value); count is decimal.
  int m_armed [2];
  int m_run   [2];
  int m_cnt   [2];
  int m_rel   [2];
  int m_tdiv  [2];
  int m_sdiv  [2];
  int m_idx   [2];
  int m_done  [2];
  int m_en    [2];
  int m_seg   [2];

  function automatic int seg_of(input int n);
    return (n > 9) ? 32'h7F : int'(seg_tab[n]);
  endfunction

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_rel[i] = 0;
      m_tdiv[i] = 0; m_sdiv[i] = 0; m_idx[i] = 0; m_done[i] = 0;
      m_en[i] = 15; m_seg[i] = 32'h7F;
    end
  endtask

  task automatic model_step(input int i);
    int         nib;
    logic [7:0] sh;
    // Display of the digit selected during the previous cycle.
    if (m_armed[i] != 0) begin
      m_en[i] = 15 & ~(1 << m_idx[i]);
      if (m_idx[i] < ND - CD) begin
        sh  = static_bcd >> (4 * m_idx[i]);
        nib = int'(sh[3:0]);
      end else if (m_idx[i] == ND - CD) begin
        nib = m_cnt[i] % 10;
      end else begin
        nib = m_cnt[i] / 10;
      end
      m_seg[i] = seg_of(nib);
      if (m_sdiv[i] == SD - 1) begin
        m_sdiv[i] = 0;
        m_idx[i]  = (m_idx[i] + 1) % ND;
      end else begin
        m_sdiv[i]++;
      end
    end else begin
      m_en[i]  = 15;
      m_seg[i] = 32'h7F;
    end
    // Countdown.
    m_done[i] = 0;
    if (start) begin
      m_cnt[i] = bcd2int(load_val); m_rel[i] = m_cnt[i];
      m_tdiv[i] = 0; m_armed[i] = 1;
      if (m_cnt[i] == 0) begin m_run[i] = 0; m_done[i] = 1; end
      else m_run[i] = 1;
    end else if (m_run[i] != 0 && !pause) begin
      if (m_tdiv[i] == TD - 1) begin
        m_tdiv[i] = 0;
        if (m_cnt[i] == 0) begin
          if (i == 1) m_cnt[i] = m_rel[i];
        end else begin
          m_cnt[i]--;
          if (m_cnt[i] == 0 && i == 0) begin m_done[i] = 1; m_run[i] = 0; end
        end
      end else begin
        m_tdiv[i]++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " ar0 led_en"},  32'(en0),   m_en[0]);
    chk({ph, " ar0 led_seg"}, 32'(seg0),  m_seg[0]);
    chk({ph, " ar0 led_dp"},  32'(dp0),   1);
    chk({ph, " ar0 running"}, 32'(run0),  m_run[0]);
    chk({ph, " ar0 done"},    32'(done0), m_done[0]);
    chk({ph, " ar1 led_en"},  32'(en1),   m_en[1]);
    chk({ph, " ar1 led_seg"}, 32'(seg1),  m_seg[1]);
    chk({ph, " ar1 led_dp"},  32'(dp1),   1);
    chk({ph, " ar1 running"}, 32'(run1),  m_run[1]);
    chk({ph, " ar1 done"},    32'(done1), m_done[1]);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (rst) model_reset();
    else begin model_step(0); model_step(1); end
    #1;
    check_all(ph);
    if (done0) dcount0++;
    if (done1) dcount1++;
  endtask

  task automatic pulse_start(input logic [7:0] v, input string ph);
    load_val = v; start = 1'b1;
    step(ph);
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] d0, d1;
    rst = 1'b1; start = 1'b0; pause = 1'b0; load_val = '0; static_bcd = 8'h4A;
    model_reset();
    #3; check_all("reset_async");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // 1: blank and idle without a start.
    repeat (100) step("blank");

    // 2/3: count 12 down (ar0 stops with done, ar1 reloads silently).
    pulse_start(8'h12, "start12");
    repeat (12 * TD + 40) step("count12");
    chk("done_pulses_ar0", dcount0, 1);
    chk("done_pulses_ar1", dcount1, 0);

    pulse_start(8'h03, "start03");
    repeat (6 * TD + 10) step("count03");
    chk("done_pulses_ar0_b", dcount0, 2);
    chk("done_pulses_ar1_b", dcount1, 0);

    // 4: pause at 07, release, restart on the 06->05 tick.
    pulse_start(8'h09, "start09");
    n = 0;
    while (m_cnt[0] != 7 && n < 400) begin step("to07"); n++; end
    chk("reach07", 32'(n < 400), 1);
    repeat (7) step("mid07");
    pause = 1'b1;
    repeat (50) step("paused");
    pause = 1'b0;
    n = 0;
    while (!(m_cnt[0] == 6 && m_tdiv[0] == TD - 1) && n < 400) begin step("to06"); n++; end
    chk("reach06_tick", 32'(n < 400), 1);
    pulse_start(8'h20, "restart20");
    repeat (2 * TD) step("count20");

    // Zero load: immediate done, not running.
    pulse_start(8'h00, "start00");
    repeat (5) step("idle00");

    // 6: async reset at count 05.
    pulse_start(8'h09, "start09b");
    n = 0;
    while (m_cnt[0] != 5 && n < 400) begin step("to05"); n++; end
    chk("reach05", 32'(n < 400), 1);
    repeat (5) step("mid05");
    #3 rst = 1'b1;
    #1 model_reset();
    check_all("rst_mid");
    step("rst_hold");
    #2 rst = 1'b0;
    n = dcount0 + dcount1;
    repeat (50) step("post_rst");
    chk("no_done_after_rst", dcount0 + dcount1, n);

    // Randomized operation.
    static_bcd = 8'h4A;
    repeat (1500) begin
      if ($urandom_range(99) < 3) static_bcd = 8'($urandom);
      pause = ($urandom_range(99) < 10);
      if ($urandom_range(99) < 2) begin
        d0 = 4'($urandom_range(9));
        d1 = 4'($urandom_range(9));
        if ($urandom_range(9) == 0) begin d0 = 4'd0; d1 = 4'd0; end
        pulse_start({d1, d0}, "rand_start");
      end else begin
        step("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
